mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for a single-ported unified memory shared by the instruction-fetch (IF) stage and the MEM stage of the 5-stage pipeline. It serializes requests, drives a variable-latency memory through a simple issue/valid handshake, and returns read data to the winner. It also produces the stall signals that hold the PC, IF_ID and the rest of the pipeline while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; held high until if_ready
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready
- if_ready  out  1  one-cycle completion pulse for IF
- d_req  in  1  MEM-stage request; held high until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready
- d_ready  out  1  one-cycle completion pulse for data
- m_en  out  1  memory issue strobe, exactly one cycle per access
- m_we  out  1  write enable, qualified by m_en
- m_addr  out  ADDR_W  memory address, held for the whole access
- m_wdata  out  DATA_W  memory write data, held for the whole access
- m_rdata  in  DATA_W  memory read data, sampled on m_valid
- m_valid  in  1  memory completion; also acts as the write acknowledge
- stall_if  out  1  if_req & ~if_ready: hold PC and insert an IF_ID bubble
- stall_pipe  out  1  d_req & ~d_ready: freeze PC, IF_ID, ID_EX and EX_MEM
- conflict_cnt  out  CNT_W  cycles in IDLE with both requests high; saturates
- proto_err  out  1  sticky: m_valid seen outside WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. An owner register holds IF or D.
- IDLE: if d_req, owner = D and the d_* inputs are latched. Otherwise, if if_req, owner = IF and if_addr is latched (m_we = 0). The next state is ISSUE. With no request, the FSM stays in IDLE.
- Priority is fixed: D wins over IF, because D belongs to the older instruction. IF cannot starve: stall_pipe holds the pipeline, so the MEM stage issues at most one request per instruction.
- ISSUE: m_en = 1 for one cycle. Next state is WAIT.
- WAIT: stay until m_valid. On m_valid, m_rdata is registered into the owner's rdata register and the FSM goes to DONE.
- DONE: the owner's ready = 1 for one cycle. Next state is IDLE.
- m_addr, m_we and m_wdata hold their latched values from ISSUE through DONE. Requester inputs that change after the IDLE latch are ignored.
- A write returns to the requester with d_ready. d_rdata is unchanged on a write.
- A req still high in the IDLE cycle after ready is treated as a new request.
- m_valid in IDLE, ISSUE or DONE is ignored and sets proto_err. proto_err clears only on reset.
- conflict_cnt increments in each IDLE cycle where if_req & d_req. It holds at its maximum value once saturated.

## Timing
- Reset (rst low, asynchronous) sets: state IDLE, m_en 0, m_we 0, m_addr 0, m_wdata 0, if_ready 0, d_ready 0, if_rdata 0, d_rdata 0, conflict_cnt 0, proto_err 0. stall_* follow their equations, so they equal the raw req inputs during reset.
- Reset asserted mid-access abandons the access. A late m_valid after reset release lands in IDLE, is ignored, and sets proto_err.
- Access latency: req seen in IDLE at cycle 0 → m_en at cycle 1 → m_valid at cycle 1+L (L ≥ 1) → ready at cycle 2+L → IDLE at cycle 3+L. The minimum is 4 cycles, with a throughput of one access per 4 cycles at L = 1.
- m_valid in the ISSUE cycle is not accepted: it sets proto_err and the FSM proceeds to WAIT.
- stall_if and stall_pipe are combinational from req and the registered ready signals. No other path runs from inputs to outputs.

## Structure
- Package mem_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, DONE) and the owner enum (OWN_IF, OWN_D).
- Sub-module sat_counter (parameter W; inputs inc and clear; output q), used for conflict_cnt.

## Test plan
- Single fetch, L = 1: if_req with if_addr = 0x40, m_rdata = 0x8C220004. Expect m_en at cycle 1 with m_addr = 0x40, if_ready at cycle 3 with if_rdata = 0x8C220004, stall_if high for cycles 0–2.
- Store, L = 3: d_req, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF. Expect m_we = 1, m_addr = 0x100 and m_wdata = 0xDEADBEEF held for cycles 1–5, d_ready at cycle 5, d_rdata unchanged.
- Simultaneous requests at cycle 0: D (load 0x200 → 0x11) is served first with d_ready at cycle 3. The IF access (0x44) is latched at cycle 4 and if_ready arrives at cycle 7. conflict_cnt = 1.
- Reset mid-WAIT: pull rst low at cycle 2 of an IF access, release it, then pulse m_valid. Expect all outputs at their reset values, state IDLE, proto_err = 1, no if_ready.
- Spurious m_valid in IDLE, then a normal access. Expect proto_err = 1 sticky while the access completes normally.
- Saturation with CNT_W = 4: hold both reqs so that 20 conflicting IDLE cycles occur. Expect conflict_cnt to reach 15 and stay there.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM state and access owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  assign q = r_q;

  // Count register: clear wins over increment, increment stops at the maximum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes IF fetches and MEM-stage loads/stores onto one variable-latency
// memory port, returns read data to the winner and generates pipeline stalls.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid,
  output logic              stall_if,
  output logic              stall_pipe,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              proto_err
);

  state_t              r_state,     w_state_nxt;
  owner_t              r_owner,     w_owner_nxt;
  logic                r_m_en,      w_m_en_nxt;
  logic                r_m_we,      w_m_we_nxt;
  logic [ADDR_W-1:0]   r_m_addr,    w_m_addr_nxt;
  logic [DATA_W-1:0]   r_m_wdata,   w_m_wdata_nxt;
  logic                r_if_ready,  w_if_ready_nxt;
  logic                r_d_ready,   w_d_ready_nxt;
  logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata_nxt;
  logic [DATA_W-1:0]   r_d_rdata,   w_d_rdata_nxt;
  logic                r_proto_err, w_proto_err_nxt;
  logic                w_conflict;

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_m_en_nxt      = 1'b0;
    w_m_we_nxt      = r_m_we;
    w_m_addr_nxt    = r_m_addr;
    w_m_wdata_nxt   = r_m_wdata;
    w_if_ready_nxt  = 1'b0;
    w_d_ready_nxt   = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_proto_err_nxt = r_proto_err | (m_valid & (r_state != WAIT));
    unique case (r_state)
      IDLE: begin
        // D belongs to the older instruction, so it always wins the port
        if (d_req) begin
          w_owner_nxt   = OWN_D;
          w_m_we_nxt    = d_we;
          w_m_addr_nxt  = d_addr;
          w_m_wdata_nxt = d_wdata;
          w_m_en_nxt    = 1'b1;
          w_state_nxt   = ISSUE;
        end else if (if_req) begin
          w_owner_nxt   = OWN_IF;
          w_m_we_nxt    = 1'b0;
          w_m_addr_nxt  = if_addr;
          w_m_en_nxt    = 1'b1;
          w_state_nxt   = ISSUE;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (m_valid) begin
          w_state_nxt = DONE;
          if (r_owner == OWN_D) begin
            w_d_ready_nxt = 1'b1;
            if (!r_m_we) begin
              w_d_rdata_nxt = m_rdata;
            end else begin
              w_d_rdata_nxt = r_d_rdata;
            end
          end else begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = m_rdata;
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_m_en      <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_m_en      <= w_m_en_nxt;
      r_m_we      <= w_m_we_nxt;
      r_m_addr    <= w_m_addr_nxt;
      r_m_wdata   <= w_m_wdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign w_conflict = (r_state == IDLE) & if_req & d_req;

  sat_counter #(
    .W(CNT_W)
  ) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_conflict),
    .clear (1'b0),
    .q     (conflict_cnt)
  );

  assign m_en       = r_m_en;
  assign m_we       = r_m_we;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign if_ready   = r_if_ready;
  assign d_ready    = r_d_ready;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign proto_err  = r_proto_err;
  assign stall_if   = if_req & ~r_if_ready;
  assign stall_pipe = d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; a second, 4-bit-counter instance checks saturation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_valid;
  logic        stall_if;
  logic        stall_pipe;
  logic [15:0] conflict_cnt;
  logic        proto_err;

  logic        rst2;
  logic [31:0] s_if_rdata, s_d_rdata, s_m_addr, s_m_wdata;
  logic        s_if_ready, s_d_ready, s_m_en, s_m_we, s_stall_if, s_stall_pipe, s_proto_err;
  logic [3:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid),
    .stall_if(stall_if), .stall_pipe(stall_pipe),
    .conflict_cnt(conflict_cnt), .proto_err(proto_err)
  );

  // Both requests and m_valid held high: one IDLE conflict cycle every 4 cycles
  mem_port_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2),
    .if_req(1'b1), .if_addr(32'h0000_0010), .if_rdata(s_if_rdata), .if_ready(s_if_ready),
    .d_req(1'b1), .d_we(1'b0), .d_addr(32'h0000_0020), .d_wdata(32'h0000_0000),
    .d_rdata(s_d_rdata), .d_ready(s_d_ready),
    .m_en(s_m_en), .m_we(s_m_we), .m_addr(s_m_addr), .m_wdata(s_m_wdata),
    .m_rdata(32'h0000_0077), .m_valid(1'b1),
    .stall_if(s_stall_if), .stall_pipe(s_stall_pipe),
    .conflict_cnt(s_cnt), .proto_err(s_proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_en"}, {63'd0, m_en}, 64'd0);
    chk({tag, "_m_we"}, {63'd0, m_we}, 64'd0);
    chk({tag, "_m_addr"}, {32'd0, m_addr}, 64'd0);
    chk({tag, "_m_wdata"}, {32'd0, m_wdata}, 64'd0);
    chk({tag, "_if_ready"}, {63'd0, if_ready}, 64'd0);
    chk({tag, "_d_ready"}, {63'd0, d_ready}, 64'd0);
    chk({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
    chk({tag, "_d_rdata"}, {32'd0, d_rdata}, 64'd0);
    chk({tag, "_cnt"}, {48'd0, conflict_cnt}, 64'd0);
    chk({tag, "_perr"}, {63'd0, proto_err}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    m_rdata = 32'd0; m_valid = 1'b0;
    tick();
    chk_reset_outputs("rst0");
    rst = 1'b1;
    tick();

    // Single fetch, L = 1
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1 chk("f_c0_stall_if", {63'd0, stall_if}, 64'd1);
    tick();
    chk("f_c1_m_en", {63'd0, m_en}, 64'd1);
    chk("f_c1_m_addr", {32'd0, m_addr}, 64'h40);
    chk("f_c1_m_we", {63'd0, m_we}, 64'd0);
    chk("f_c1_stall_if", {63'd0, stall_if}, 64'd1);
    tick();
    chk("f_c2_m_en", {63'd0, m_en}, 64'd0);
    chk("f_c2_stall_if", {63'd0, stall_if}, 64'd1);
    m_valid = 1'b1; m_rdata = 32'h8C22_0004;
    tick();
    m_valid = 1'b0;
    chk("f_c3_if_ready", {63'd0, if_ready}, 64'd1);
    chk("f_c3_if_rdata", {32'd0, if_rdata}, 64'h8C22_0004);
    chk("f_c3_stall_if", {63'd0, stall_if}, 64'd0);
    if_req = 1'b0;
    tick();
    chk("f_c4_if_ready", {63'd0, if_ready}, 64'd0);
    chk("f_c4_perr", {63'd0, proto_err}, 64'd0);

    // Store, L = 3; inputs changed after the latch must be ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    #1 chk("s_c0_stall_pipe", {63'd0, stall_pipe}, 64'd1);
    tick();
    chk("s_c1_m_en", {63'd0, m_en}, 64'd1);
    chk("s_c1_m_we", {63'd0, m_we}, 64'd1);
    chk("s_c1_m_addr", {32'd0, m_addr}, 64'h100);
    chk("s_c1_m_wdata", {32'd0, m_wdata}, 64'hDEAD_BEEF);
    d_addr = 32'h0000_0999; d_wdata = 32'h1111_1111; d_we = 1'b0;
    tick();
    chk("s_c2_m_en", {63'd0, m_en}, 64'd0);
    chk("s_c2_m_addr", {32'd0, m_addr}, 64'h100);
    tick();
    chk("s_c3_m_wdata", {32'd0, m_wdata}, 64'hDEAD_BEEF);
    tick();
    m_valid = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    m_valid = 1'b0;
    chk("s_c5_d_ready", {63'd0, d_ready}, 64'd1);
    chk("s_c5_d_rdata", {32'd0, d_rdata}, 64'd0);
    chk("s_c5_m_we", {63'd0, m_we}, 64'd1);
    chk("s_c5_m_addr", {32'd0, m_addr}, 64'h100);
    chk("s_c5_m_wdata", {32'd0, m_wdata}, 64'hDEAD_BEEF);
    chk("s_c5_stall_pipe", {63'd0, stall_pipe}, 64'd0);
    d_req = 1'b0;
    tick();
    chk("s_c6_d_ready", {63'd0, d_ready}, 64'd0);

    // Simultaneous requests: D load first, then IF
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    tick();
    chk("c_c1_m_addr", {32'd0, m_addr}, 64'h200);
    chk("c_c1_m_we", {63'd0, m_we}, 64'd0);
    chk("c_c1_m_en", {63'd0, m_en}, 64'd1);
    chk("c_c1_stalls", {62'd0, stall_if, stall_pipe}, 64'd3);
    tick();
    m_valid = 1'b1; m_rdata = 32'h0000_0011;
    tick();
    m_valid = 1'b0;
    chk("c_c3_d_ready", {63'd0, d_ready}, 64'd1);
    chk("c_c3_d_rdata", {32'd0, d_rdata}, 64'h11);
    chk("c_c3_if_ready", {63'd0, if_ready}, 64'd0);
    d_req = 1'b0;
    tick();
    chk("c_c4_cnt", {48'd0, conflict_cnt}, 64'd1);
    chk("c_c4_m_en", {63'd0, m_en}, 64'd0);
    tick();
    chk("c_c5_m_en", {63'd0, m_en}, 64'd1);
    chk("c_c5_m_addr", {32'd0, m_addr}, 64'h44);
    tick();
    m_valid = 1'b1; m_rdata = 32'hAABB_CCDD;
    tick();
    m_valid = 1'b0;
    chk("c_c7_if_ready", {63'd0, if_ready}, 64'd1);
    chk("c_c7_if_rdata", {32'd0, if_rdata}, 64'hAABB_CCDD);
    chk("c_c7_d_rdata", {32'd0, d_rdata}, 64'h11);
    chk("c_c7_cnt", {48'd0, conflict_cnt}, 64'd1);
    if_req = 1'b0;
    tick();

    // Reset during WAIT, then a late m_valid
    if_req = 1'b1; if_addr = 32'h0000_0080;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("rw");
    chk("rw_stall_if", {63'd0, stall_if}, 64'd1);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    m_valid = 1'b1; m_rdata = 32'h5555_5555;
    tick();
    m_valid = 1'b0;
    chk("rw_perr", {63'd0, proto_err}, 64'd1);
    chk("rw_if_ready", {63'd0, if_ready}, 64'd0);
    chk("rw_m_en", {63'd0, m_en}, 64'd0);
    tick();
    chk("rw_if_ready2", {63'd0, if_ready}, 64'd0);
    chk("rw_if_rdata", {32'd0, if_rdata}, 64'd0);

    // Spurious m_valid in IDLE, then a normal load with L = 2
    rst = 1'b0;
    tick();
    chk("sp_perr_clr", {63'd0, proto_err}, 64'd0);
    rst = 1'b1;
    tick();
    m_valid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    m_valid = 1'b0;
    chk("sp_perr_set", {63'd0, proto_err}, 64'd1);
    chk("sp_m_en", {63'd0, m_en}, 64'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    tick();
    chk("sp_c1_m_addr", {32'd0, m_addr}, 64'h300);
    tick();
    tick();
    m_valid = 1'b1; m_rdata = 32'h0000_55AA;
    tick();
    m_valid = 1'b0;
    chk("sp_c4_d_ready", {63'd0, d_ready}, 64'd1);
    chk("sp_c4_d_rdata", {32'd0, d_rdata}, 64'h55AA);
    chk("sp_c4_perr", {63'd0, proto_err}, 64'd1);
    d_req = 1'b0;
    tick();

    // Saturation: IDLE conflict cycles at 0,4,8,...; after n edges count = ceil(n/4)
    rst2 = 1'b1;
    repeat (6) tick();
    chk("sat_6", {60'd0, s_cnt}, 64'd2);
    repeat (47) tick();
    chk("sat_53", {60'd0, s_cnt}, 64'd14);
    repeat (4) tick();
    chk("sat_57", {60'd0, s_cnt}, 64'd15);
    repeat (23) tick();
    chk("sat_80", {60'd0, s_cnt}, 64'd15);
    repeat (20) tick();
    chk("sat_100", {60'd0, s_cnt}, 64'd15);
    chk("sat_perr", {63'd0, s_proto_err}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
